// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Write-back arbiter in front of the register file's single write port.
// The in-order pipeline write always wins the port. Long-latency unit results
// are accepted through a valid/ready handshake into a small in-order FIFO.
// The FIFO drains into any cycle the pipeline leaves the port idle.
//
// Optional build macro: WB_R0_FILTER_EN
//   defined   : writes to register 0 are dropped at the input (pipeline slot
//               becomes free for a FIFO drain; long-unit handshake completes
//               but nothing is queued)
//   undefined : register-0 writes pass through unchanged
//
// Ports
//   clk        : clock, all state updates on posedge
//   rst_n      : synchronous reset, active-low
//   p_wen      : pipeline write request this cycle
//   p_waddr    : pipeline destination register
//   p_wdata    : pipeline write data
//   lu_valid   : long-unit result valid
//   lu_ready   : buffer can accept a long-unit result
//   lu_waddr   : long-unit destination register
//   lu_wdata   : long-unit write data
//   RegWrite   : register-file write enable (registered)
//   rc         : register-file write address (registered)
//   dc         : register-file write data (registered)
//   fifo_count : entries currently queued
//   pipe_stall : buffer full; upstream must stall the long unit
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          p_wen,
    input  logic [AW-1:0]                 p_waddr,
    input  logic [DW-1:0]                 p_wdata,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [AW-1:0]                 lu_waddr,
    input  logic [DW-1:0]                 lu_wdata,
    output logic                          RegWrite,
    output logic [AW-1:0]                 rc,
    output logic [DW-1:0]                 dc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          pipe_stall
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

    // FIFO storage and state
    logic [AW-1:0] mem_addr_r [FIFO_DEPTH];
    logic [DW-1:0] mem_data_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;

    // Registered write-port outputs
    logic          regwrite_r;
    logic [AW-1:0] rc_r;
    logic [DW-1:0] dc_r;

    logic          ready_s;
    logic          lu_fire_s;
    logic          p_take_s;
    logic          push_s;
    logic          pop_s;

    // Readiness comes only from the registered count, never from lu_valid.
    assign ready_s   = (count_r != CNT_FULL);
    assign lu_fire_s = lu_valid && ready_s;

`ifdef WB_R0_FILTER_EN
    // r0 writes are swallowed: the handshake still completes, nothing queued.
    assign p_take_s = p_wen && (p_waddr != REG_ZERO);
    assign push_s   = lu_fire_s && (lu_waddr != REG_ZERO);
`else
    assign p_take_s = p_wen;
    assign push_s   = lu_fire_s;
`endif

    // A dropped r0 pipeline write leaves the slot free for a drain.
    assign pop_s = !p_take_s && (count_r != CNT_ZERO);

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; reset discards all queued entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Entry storage; contents are don't-care until written by an accepted push
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_addr_r[wr_ptr_r] <= lu_waddr;
            mem_data_r[wr_ptr_r] <= lu_wdata;
        end
    end

    // Write-port selection: pipeline first, then FIFO head, else idle (rc/dc hold)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_r <= 1'b0;
            rc_r       <= REG_ZERO;
            dc_r       <= {DW{1'b0}};
        end else if (p_take_s) begin
            regwrite_r <= 1'b1;
            rc_r       <= p_waddr;
            dc_r       <= p_wdata;
        end else if (pop_s) begin
            regwrite_r <= 1'b1;
            rc_r       <= mem_addr_r[rd_ptr_r];
            dc_r       <= mem_data_r[rd_ptr_r];
        end else begin
            regwrite_r <= 1'b0;
        end
    end

    assign RegWrite   = regwrite_r;
    assign rc         = rc_r;
    assign dc         = dc_r;
    assign fifo_count = count_r;
    assign lu_ready   = ready_s;
    assign pipe_stall = (count_r == CNT_FULL);

endmodule
